// File: rtl/ft245_axi_ram.sv
`default_nettype none
// ============================================================================
// ft245_axi_ram : AXI4 single-burst responder backed by word-addressed RAM
// Revision      : 1.0 - initial release
// ============================================================================
module ft245_axi_ram #(
  parameter int ADDR_W = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inport_awvalid_i,
  output logic        inport_awready_o,
  input  logic [31:0] inport_awaddr_i,
  input  logic [3:0]  inport_awid_i,
  input  logic [7:0]  inport_awlen_i,
  input  logic [1:0]  inport_awburst_i,
  input  logic        inport_wvalid_i,
  output logic        inport_wready_o,
  input  logic [31:0] inport_wdata_i,
  input  logic [3:0]  inport_wstrb_i,
  input  logic        inport_wlast_i,
  output logic        inport_bvalid_o,
  input  logic        inport_bready_i,
  output logic [1:0]  inport_bresp_o,
  output logic [3:0]  inport_bid_o,
  input  logic        inport_arvalid_i,
  output logic        inport_arready_o,
  input  logic [31:0] inport_araddr_i,
  input  logic [3:0]  inport_arid_i,
  input  logic [7:0]  inport_arlen_i,
  input  logic [1:0]  inport_arburst_i,
  output logic        inport_rvalid_o,
  input  logic        inport_rready_i,
  output logic [31:0] inport_rdata_o,
  output logic [1:0]  inport_rresp_o,
  output logic [3:0]  inport_rid_o,
  output logic        inport_rlast_o
);

  localparam int         C_DEPTH       = 1 << ADDR_W;
  localparam logic [1:0] C_FIXED       = 2'b00;
  localparam logic [1:0] C_INCR        = 2'b01;
  localparam logic [1:0] C_WRAP        = 2'b10;
  localparam logic [1:0] C_RESP_OK     = 2'b00;
  localparam logic [1:0] C_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WRESP = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  function automatic logic [31:0] f_next_addr(input logic [31:0] addr,
                                              input logic [1:0]  burst,
                                              input logic [7:0]  len);
    logic [31:0] mask;
    mask = {22'd0, len, 2'b11};
    case (burst)
      C_FIXED: return addr;
      C_WRAP:  return (addr & ~mask) | ((addr + 32'd4) & mask);
      default: return addr + 32'd4;
    endcase
  endfunction

  // Reserved burst type and odd WRAP lengths still run, as INCR, but flag SLVERR
  function automatic logic f_bad_burst(input logic [1:0] burst, input logic [7:0] len);
    logic wrap_ok;
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (burst == 2'b11) || ((burst == C_WRAP) && !wrap_ok);
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_init;
  logic        r_prio_wr;
  logic [31:0] r_addr;
  logic [3:0]  r_id;
  logic [7:0]  r_len;
  logic [1:0]  r_burst;
  logic [7:0]  r_beat;
  logic        r_err;
  logic [31:0] r_rdata;
  logic [31:0] r_mem [C_DEPTH];

  logic        w_live;
  logic        w_aw_pick, w_ar_pick;
  logic        w_awready, w_arready, w_wready, w_bvalid, w_rvalid;
  logic        w_aw_fire, w_ar_fire, w_w_fire, w_r_fire;
  logic        w_last_beat;
  logic        w_aw_bad, w_ar_bad;
  logic [31:0] w_addr_nxt;
  logic [ADDR_W-1:0] w_idx, w_ar_idx, w_nxt_idx;
  logic        w_unused;

  // Handshakes are held off for one cycle after reset release as well
  assign w_live      = !rst_i && !r_init;
  assign w_aw_pick   = inport_awvalid_i && (r_prio_wr || !inport_arvalid_i);
  assign w_ar_pick   = inport_arvalid_i && (!r_prio_wr || !inport_awvalid_i);
  assign w_last_beat = (r_beat == r_len);
  assign w_addr_nxt  = f_next_addr(r_addr, r_burst, r_len);
  assign w_idx       = r_addr[ADDR_W+1:2];
  assign w_nxt_idx   = w_addr_nxt[ADDR_W+1:2];
  assign w_ar_idx    = inport_araddr_i[ADDR_W+1:2];
  assign w_aw_bad    = f_bad_burst(inport_awburst_i, inport_awlen_i);
  assign w_ar_bad    = f_bad_burst(inport_arburst_i, inport_arlen_i);
  assign w_unused    = ^{inport_araddr_i[31:ADDR_W+2], inport_araddr_i[1:0]};

  assign w_aw_fire = w_awready && inport_awvalid_i;
  assign w_ar_fire = w_arready && inport_arvalid_i;
  assign w_w_fire  = w_wready && inport_wvalid_i;
  assign w_r_fire  = w_rvalid && inport_rready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_init  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_init  <= 1'b0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_awready   = 1'b0;
    w_arready   = 1'b0;
    w_wready    = 1'b0;
    w_bvalid    = 1'b0;
    w_rvalid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_awready = w_live && w_aw_pick;
        w_arready = w_live && w_ar_pick;
        if (w_awready)      w_state_nxt = ST_WRITE;
        else if (w_arready) w_state_nxt = ST_READ;
      end
      ST_WRITE: begin
        w_wready = w_live;
        if (w_live && inport_wvalid_i && w_last_beat) w_state_nxt = ST_WRESP;
      end
      ST_WRESP: begin
        w_bvalid = w_live;
        if (w_live && inport_bready_i) w_state_nxt = ST_IDLE;
      end
      ST_READ: begin
        w_rvalid = w_live;
        if (w_live && inport_rready_i && w_last_beat) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_prio_wr <= 1'b1;
      r_addr    <= 32'd0;
      r_id      <= 4'd0;
      r_len     <= 8'd0;
      r_burst   <= C_INCR;
      r_beat    <= 8'd0;
      r_err     <= 1'b0;
      r_rdata   <= 32'd0;
    end else if (w_aw_fire) begin
      r_prio_wr <= 1'b0;
      r_addr    <= inport_awaddr_i;
      r_id      <= inport_awid_i;
      r_len     <= inport_awlen_i;
      r_burst   <= w_aw_bad ? C_INCR : inport_awburst_i;
      r_beat    <= 8'd0;
      r_err     <= w_aw_bad;
    end else if (w_ar_fire) begin
      r_prio_wr <= 1'b1;
      r_addr    <= inport_araddr_i;
      r_id      <= inport_arid_i;
      r_len     <= inport_arlen_i;
      r_burst   <= w_ar_bad ? C_INCR : inport_arburst_i;
      r_beat    <= 8'd0;
      r_err     <= w_ar_bad;
      r_rdata   <= r_mem[w_ar_idx];
    end else if (w_w_fire) begin
      r_addr <= w_addr_nxt;
      r_beat <= r_beat + 8'd1;
      if (inport_wlast_i != w_last_beat) r_err <= 1'b1;
    end else if (w_r_fire) begin
      r_addr  <= w_addr_nxt;
      r_beat  <= r_beat + 8'd1;
      r_rdata <= r_mem[w_nxt_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_w_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (inport_wstrb_i[b]) r_mem[w_idx][8*b +: 8] <= inport_wdata_i[8*b +: 8];
      end
    end
  end

  assign inport_awready_o = w_awready;
  assign inport_arready_o = w_arready;
  assign inport_wready_o  = w_wready;
  assign inport_bvalid_o  = w_bvalid;
  assign inport_bresp_o   = (w_bvalid && r_err) ? C_RESP_SLVERR : C_RESP_OK;
  assign inport_bid_o     = w_bvalid ? r_id : 4'd0;
  assign inport_rvalid_o  = w_rvalid;
  assign inport_rdata_o   = w_rvalid ? r_rdata : 32'd0;
  assign inport_rresp_o   = (w_rvalid && r_err) ? C_RESP_SLVERR : C_RESP_OK;
  assign inport_rid_o     = w_rvalid ? r_id : 4'd0;
  assign inport_rlast_o   = w_rvalid && w_last_beat;

endmodule
`default_nettype wire

// File: tb/tb_ft245_axi_ram.sv
`default_nettype none
// ============================================================================
// tb_ft245_axi_ram : scoreboard bench for the ft245_axi_ram AXI4 responder
// Revision         : 1.0 - initial release
// ============================================================================
module tb_ft245_axi_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        awvalid = 0, awready;
  logic [31:0] awaddr = 0;
  logic [3:0]  awid = 0;
  logic [7:0]  awlen = 0;
  logic [1:0]  awburst = 0;
  logic        wvalid = 0, wready;
  logic [31:0] wdata = 0;
  logic [3:0]  wstrb = 0;
  logic        wlast = 0;
  logic        bvalid, bready = 0;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid = 0, arready;
  logic [31:0] araddr = 0;
  logic [3:0]  arid = 0;
  logic [7:0]  arlen = 0;
  logic [1:0]  arburst = 0;
  logic        rvalid, rready = 0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic        rlast;

  ft245_axi_ram dut (
    .clk_i(clk), .rst_i(rst),
    .inport_awvalid_i(awvalid), .inport_awready_o(awready), .inport_awaddr_i(awaddr),
    .inport_awid_i(awid), .inport_awlen_i(awlen), .inport_awburst_i(awburst),
    .inport_wvalid_i(wvalid), .inport_wready_o(wready), .inport_wdata_i(wdata),
    .inport_wstrb_i(wstrb), .inport_wlast_i(wlast),
    .inport_bvalid_o(bvalid), .inport_bready_i(bready), .inport_bresp_o(bresp), .inport_bid_o(bid),
    .inport_arvalid_i(arvalid), .inport_arready_o(arready), .inport_araddr_i(araddr),
    .inport_arid_i(arid), .inport_arlen_i(arlen), .inport_arburst_i(arburst),
    .inport_rvalid_o(rvalid), .inport_rready_i(rready), .inport_rdata_o(rdata),
    .inport_rresp_o(rresp), .inport_rid_o(rid), .inport_rlast_o(rlast)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic [3:0]  id;
    logic        last;
  } beat_t;

  int    errors = 0;
  int    checks = 0;
  beat_t exp_q[$];
  beat_t got_q[$];
  logic [31:0] wr_data [16];
  logic [3:0]  wr_strb [16];
  logic        wr_last [16];
  int    rd_unstable, rd_extra, rd_first_wait, b_wait;
  int    both_ready = 0;

  always @(negedge clk) if (awready && arready) both_ready++;

  task automatic fill_burst(input logic [31:0] base, input int len);
    for (int i = 0; i < 16; i++) begin
      wr_data[i] = base + 32'(i);
      wr_strb[i] = 4'hF;
      wr_last[i] = (i == len);
    end
  endtask

  task automatic axi_aw(input logic [31:0] addr, input logic [3:0] id,
                        input logic [7:0] len, input logic [1:0] burst);
    int w = 0;
    awaddr = addr; awid = id; awlen = len; awburst = burst; awvalid = 1;
    @(negedge clk);
    while (!awready && w < 50) begin @(negedge clk); w++; end
    if (w >= 50) begin checks++; errors++; $display("FAIL aw_timeout: awready=%0b want 1", awready); end
    @(posedge clk); #1;
    awvalid = 0;
  endtask

  task automatic axi_ar(input logic [31:0] addr, input logic [3:0] id,
                        input logic [7:0] len, input logic [1:0] burst);
    int w = 0;
    araddr = addr; arid = id; arlen = len; arburst = burst; arvalid = 1;
    @(negedge clk);
    while (!arready && w < 50) begin @(negedge clk); w++; end
    if (w >= 50) begin checks++; errors++; $display("FAIL ar_timeout: arready=%0b want 1", arready); end
    @(posedge clk); #1;
    arvalid = 0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst, output logic [1:0] resp, output logic [3:0] id_o);
    int w;
    axi_aw(addr, id, len, burst);
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1; wdata = wr_data[i]; wstrb = wr_strb[i]; wlast = wr_last[i];
      w = 0;
      @(negedge clk);
      while (!wready && w < 50) begin @(negedge clk); w++; end
      if (w >= 50) begin checks++; errors++; $display("FAIL w_timeout: wready=%0b want 1", wready); end
      @(posedge clk); #1;
    end
    wvalid = 0; wlast = 0;
    bready = 1; b_wait = 0;
    @(negedge clk);
    while (!bvalid && b_wait < 50) begin @(negedge clk); b_wait++; end
    if (b_wait >= 50) begin checks++; errors++; $display("FAIL b_timeout: bvalid=%0b want 1", bvalid); end
    resp = bresp; id_o = bid;
    @(posedge clk); #1;
    bready = 0;
  endtask

  // Collects beats into got_q; a toggling rready exercises hold stability
  task automatic axi_read(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input bit toggle);
    int cyc = 0;
    bit done = 0, held_ok = 0;
    logic [38:0] held = '0;
    axi_ar(addr, id, len, burst);
    rd_unstable = 0; rd_first_wait = -1;
    while (!done && cyc < 200) begin
      rready = toggle ? cyc[0] : 1'b1;
      @(negedge clk);
      if (rvalid) begin
        if (rd_first_wait < 0) rd_first_wait = cyc;
        if (held_ok && {rdata, rlast, rid, rresp} !== held) rd_unstable++;
        if (rready) begin
          got_q.push_back('{data: rdata, resp: rresp, id: rid, last: rlast});
          held_ok = 0;
          if (rlast) done = 1;
        end else begin
          held = {rdata, rlast, rid, rresp};
          held_ok = 1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    rready = 0;
    if (!done) begin checks++; errors++; $display("FAIL r_timeout: rlast never seen, beats=%0d", got_q.size()); end
    @(negedge clk);
    rd_extra = rvalid ? 1 : 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    awvalid = 1; arvalid = 1;
    @(negedge clk);
    checks++;
    if ({awready, arready, wready, bvalid, rvalid} !== 5'b0) begin
      errors++; $display("FAIL reset_hs: got %b want 00000", {awready, arready, wready, bvalid, rvalid});
    end
    checks++;
    if ({bresp, bid, rdata, rresp, rid, rlast} !== 45'd0) begin
      errors++; $display("FAIL reset_out: got %h want 0", {bresp, bid, rdata, rresp, rid, rlast});
    end
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checks++;
    if ({awready, arready, wready, bvalid, rvalid} !== 5'b0) begin
      errors++; $display("FAIL post_reset_hs: got %b want 00000", {awready, arready, wready, bvalid, rvalid});
    end
    @(posedge clk); #1;
    awvalid = 0; arvalid = 0;
  endtask

  task automatic test_arbitration();
    awaddr = 32'h80; awid = 4'd1; awlen = 0; awburst = 2'b01; awvalid = 1;
    araddr = 32'h80; arid = 4'd2; arlen = 0; arburst = 2'b01; arvalid = 1;
    @(negedge clk);
    checks++;
    if ({awready, arready} !== 2'b10) begin errors++; $display("FAIL arb_first: got %b want 10", {awready, arready}); end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 1; wdata = 32'h12345678; wstrb = 4'hF; wlast = 1;
    @(negedge clk);
    checks++;
    if ({wready, arready} !== 2'b10) begin errors++; $display("FAIL arb_wready: got %b want 10", {wready, arready}); end
    @(posedge clk); #1;
    wvalid = 0; wlast = 0; bready = 1;
    @(negedge clk);
    checks++;
    if ({bvalid, arready, bid} !== {2'b10, 4'd1}) begin
      errors++; $display("FAIL arb_b: got %b want 10_0001", {bvalid, arready, bid});
    end
    @(posedge clk); #1;
    bready = 0;
    @(negedge clk);
    checks++;
    if (arready !== 1'b1) begin errors++; $display("FAIL arb_second: arready=%b want 1", arready); end
    @(posedge clk); #1;
    arvalid = 0; rready = 1;
    @(negedge clk);
    checks++;
    if ({rvalid, rdata, rid, rlast} !== {1'b1, 32'h12345678, 4'd2, 1'b1}) begin
      errors++; $display("FAIL arb_rdata: got %h want %h", {rvalid, rdata, rid, rlast}, {1'b1, 32'h12345678, 4'd2, 1'b1});
    end
    @(posedge clk); #1;
    rready = 0;
    // A lone write hands priority to the read side for the next collision
    begin
      logic [1:0] r; logic [3:0] i;
      fill_burst(32'h55, 0);
      axi_write(32'h84, 4'd4, 0, 2'b01, r, i);
    end
    awaddr = 32'h88; awvalid = 1;
    araddr = 32'h84; arid = 4'd7; arlen = 0; arburst = 2'b01; arvalid = 1;
    @(negedge clk);
    checks++;
    if ({awready, arready} !== 2'b01) begin errors++; $display("FAIL arb_rr: got %b want 01", {awready, arready}); end
    @(posedge clk); #1;
    awvalid = 0; arvalid = 0; rready = 1;
    @(negedge clk);
    checks++;
    if ({rvalid, rdata, rid} !== {1'b1, 32'h55, 4'd7}) begin
      errors++; $display("FAIL arb_rr_data: got %h want %h", {rvalid, rdata, rid}, {1'b1, 32'h55, 4'd7});
    end
    @(posedge clk); #1;
    rready = 0;
    checks++;
    if (both_ready !== 0) begin errors++; $display("FAIL arb_both_ready: cycles=%0d want 0", both_ready); end
  endtask

  task automatic test_single();
    logic [1:0] r; logic [3:0] i; beat_t e, g;
    fill_burst(32'hDEADBEEF, 0);
    axi_write(32'h100, 4'd3, 0, 2'b01, r, i);
    checks++;
    if ({r, i} !== {2'b00, 4'd3}) begin errors++; $display("FAIL single_b: got %h want %h", {r, i}, {2'b00, 4'd3}); end
    checks++;
    if (b_wait !== 0) begin errors++; $display("FAIL single_b_latency: got %0d want 0", b_wait); end
    exp_q.push_back('{data: 32'hDEADBEEF, resp: 2'b00, id: 4'd5, last: 1'b1});
    axi_read(32'h100, 4'd5, 0, 2'b01, 0);
    checks++;
    if (rd_first_wait !== 0) begin errors++; $display("FAIL single_r_latency: got %0d want 0", rd_first_wait); end
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL single_beat: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_incr_strobe();
    logic [1:0] r; logic [3:0] i; beat_t e, g;
    fill_burst(32'h0, 3);
    for (int k = 0; k < 4; k++) wr_data[k] = 32'hFFFFFFFF;
    axi_write(32'h200, 4'd1, 3, 2'b01, r, i);
    fill_burst(32'h1, 3);
    wr_strb[2] = 4'h1;
    axi_write(32'h200, 4'd9, 3, 2'b01, r, i);
    checks++;
    if ({r, i} !== {2'b00, 4'd9}) begin errors++; $display("FAIL incr_b: got %h want %h", {r, i}, {2'b00, 4'd9}); end
    exp_q.push_back('{data: 32'h1, resp: 2'b00, id: 4'd6, last: 1'b0});
    exp_q.push_back('{data: 32'h2, resp: 2'b00, id: 4'd6, last: 1'b0});
    exp_q.push_back('{data: 32'hFFFFFF03, resp: 2'b00, id: 4'd6, last: 1'b0});
    exp_q.push_back('{data: 32'h4, resp: 2'b00, id: 4'd6, last: 1'b1});
    axi_read(32'h200, 4'd6, 3, 2'b01, 1);
    checks++;
    if (rd_unstable !== 0) begin errors++; $display("FAIL incr_stable: changes=%0d want 0", rd_unstable); end
    checks++;
    if (rd_extra !== 0) begin errors++; $display("FAIL incr_extra_beat: rvalid=%0d want 0", rd_extra); end
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL incr_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL incr_beat: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_wrap_fixed();
    logic [1:0] r; logic [3:0] i; beat_t e, g;
    fill_burst(32'hA0, 3);
    axi_write(32'h38, 4'd2, 3, 2'b10, r, i);
    checks++;
    if (r !== 2'b00) begin errors++; $display("FAIL wrap_b: got %b want 00", r); end
    // Linear read of the 16-byte block shows where each wrapped beat landed
    exp_q.push_back('{data: 32'hA2, resp: 2'b00, id: 4'd3, last: 1'b0});
    exp_q.push_back('{data: 32'hA3, resp: 2'b00, id: 4'd3, last: 1'b0});
    exp_q.push_back('{data: 32'hA0, resp: 2'b00, id: 4'd3, last: 1'b0});
    exp_q.push_back('{data: 32'hA1, resp: 2'b00, id: 4'd3, last: 1'b1});
    axi_read(32'h30, 4'd3, 3, 2'b01, 0);
    for (int k = 0; k < 4; k++)
      exp_q.push_back('{data: 32'hA0 + 32'(k), resp: 2'b00, id: 4'd4, last: (k == 3)});
    axi_read(32'h38, 4'd4, 3, 2'b10, 0);
    fill_burst(32'hB0, 2);
    axi_write(32'h40, 4'd2, 2, 2'b00, r, i);
    for (int k = 0; k < 3; k++)
      exp_q.push_back('{data: 32'hB2, resp: 2'b00, id: 4'd8, last: (k == 2)});
    axi_read(32'h40, 4'd8, 2, 2'b00, 0);
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL wrap_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL wrap_fixed_beat: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_errors();
    logic [1:0] r; logic [3:0] i; beat_t e, g;
    fill_burst(32'hC0, 3);
    wr_last[1] = 1'b1;
    axi_write(32'h400, 4'd5, 3, 2'b01, r, i);
    checks++;
    if ({r, i} !== {2'b10, 4'd5}) begin errors++; $display("FAIL err_wlast_b: got %h want %h", {r, i}, {2'b10, 4'd5}); end
    fill_burst(32'hD0, 1);
    axi_write(32'h410, 4'd6, 1, 2'b11, r, i);
    checks++;
    if (r !== 2'b10) begin errors++; $display("FAIL err_burst11_b: got %b want 10", r); end
    for (int k = 0; k < 4; k++)
      exp_q.push_back('{data: 32'hC0 + 32'(k), resp: 2'b00, id: 4'd1, last: (k == 3)});
    axi_read(32'h400, 4'd1, 3, 2'b01, 0);
    for (int k = 0; k < 2; k++)
      exp_q.push_back('{data: 32'hD0 + 32'(k), resp: 2'b00, id: 4'd2, last: (k == 1)});
    axi_read(32'h410, 4'd2, 1, 2'b01, 0);
    for (int k = 0; k < 3; k++)
      exp_q.push_back('{data: 32'hC0 + 32'(k), resp: 2'b10, id: 4'd3, last: (k == 2)});
    axi_read(32'h400, 4'd3, 2, 2'b10, 0);
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL err_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL err_beat: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_midburst();
    logic [1:0] r; logic [3:0] i; beat_t e, g;
    fill_burst(32'hE0, 7);
    axi_write(32'h300, 4'd1, 7, 2'b01, r, i);
    axi_ar(32'h300, 4'd2, 7, 2'b01);
    rready = 1;
    @(negedge clk);
    checks++;
    if ({rvalid, rdata} !== {1'b1, 32'hE0}) begin errors++; $display("FAIL mid_beat1: got %h want %h", {rvalid, rdata}, {1'b1, 32'hE0}); end
    @(posedge clk); #1;
    rready = 0;
    @(negedge clk);
    checks++;
    if ({rvalid, rdata} !== {1'b1, 32'hE1}) begin errors++; $display("FAIL mid_beat2: got %h want %h", {rvalid, rdata}, {1'b1, 32'hE1}); end
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    checks++;
    if ({rvalid, bvalid, rdata, rlast} !== 35'd0) begin
      errors++; $display("FAIL mid_after_reset: got %h want 0", {rvalid, bvalid, rdata, rlast});
    end
    @(posedge clk); #1;
    exp_q.push_back('{data: 32'hE1, resp: 2'b00, id: 4'd9, last: 1'b1});
    axi_read(32'h304, 4'd9, 0, 2'b01, 0);
    checks++;
    if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL mid_count: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL mid_beat: got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_arbitration();
    test_single();
    test_incr_strobe();
    test_wrap_fixed();
    test_errors();
    test_reset_midburst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
